alu_muldiv_iter: RTL

- Iterative multiply/divide unit for the RV32M extension; sits in the execute stage beside the N-bit ALU.
- Takes the same rs1/rs2 operands as the ALU.
- Its result is muxed with the ALU output before write-back.
- Multi-cycle: the control path stalls the PC while busy_o is high.

---
 rtl/alu_muldiv_iter_pkg.sv | 45 ++++
 rtl/alu_muldiv_iter_if.sv | 26 ++
 rtl/alu_muldiv_iter_step.sv | 40 ++++
 rtl/alu_muldiv_iter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/alu_muldiv_iter_pkg.sv
// rtl/alu_muldiv_iter_pkg.sv - shared op codes, state codes and op decode helpers for the iterative mul/div unit
//
// Package muldiv_pkg
//   MD_MUL..MD_REMU : RV32M funct3 operation codes
//   S_IDLE/S_CALC/S_FIX : FSM state codes
//   is_div, is_rem, signed_a, signed_b : op decode helpers
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // MUL only keeps the low half, which is sign-agnostic, so it runs unsigned.
    function automatic logic signed_a(input logic [2:0] op);
        case (op)
            MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic signed_b(input logic [2:0] op);
        case (op)
            MD_MULH, MD_DIV, MD_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_iter_if.sv
// rtl/alu_muldiv_iter_if.sv - request/response bundle between the execute stage and the mul/div unit
//
// master : drives start_i, op_i, a_i, b_i; observes busy_o, done_o, result_o, zeroflag_o
// slave  : the mul/div unit itself
interface alu_muldiv_iter_if #(
    parameter int N = 32
);
    logic         start_i;
    logic [2:0]   op_i;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] result_o;
    logic         zeroflag_o;

    modport master (
        output start_i, op_i, a_i, b_i,
        input  busy_o, done_o, result_o, zeroflag_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i,
        output busy_o, done_o, result_o, zeroflag_o
    );
endinterface

// File: rtl/alu_muldiv_iter_step.sv
// rtl/alu_muldiv_iter_step.sv - one combinational shift-add / restoring-divide iteration on the 2N-bit accumulator
//
// Module muldiv_step #(N)
//   is_div : 1 selects trial-subtract, 0 selects shift-add
//   acc_i  : accumulator {hi, lo}; multiply: {partial product, remaining multiplier}
//            divide: {partial remainder, remaining dividend / quotient bits}
//   b_i    : N+1-bit magnitude of operand B
//   acc_o  : accumulator after one iteration
module muldiv_step #(
    parameter int N = 32
) (
    input  logic           is_div,
    input  logic [2*N-1:0] acc_i,
    input  logic [N:0]     b_i,
    output logic [2*N-1:0] acc_o
);

    logic [N:0] sum;
    logic [N:0] trial;

    always_comb begin
        sum   = '0;
        trial = '0;
        acc_o = acc_i;
        if (is_div) begin
            // Shift the next dividend bit into the partial remainder and try the subtract.
            trial = acc_i[2*N-1:N-1];
            if (trial >= b_i) begin
                acc_o = {N'(trial - b_i), acc_i[N-2:0], 1'b1};
            end else begin
                acc_o = {trial[N-1:0], acc_i[N-2:0], 1'b0};
            end
        end else begin
            // The carry out of the add becomes the top bit after the right shift.
            sum   = {1'b0, acc_i[2*N-1:N]} + (acc_i[0] ? b_i : {(N+1){1'b0}});
            acc_o = {sum, acc_i[N-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative RV32M multiply/divide unit (IDLE -> CALC -> FIX)
//
// Ports
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : alu_muldiv_iter_if.slave (start_i, op_i, a_i, b_i, busy_o, done_o, result_o, zeroflag_o)
// Optional build macro MULDIV_EARLY_OUT_EN: a zero operand skips CALC and completes one edge after start.
module alu_muldiv_iter #(
    parameter int N = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    alu_muldiv_iter_if.slave     bus
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(N);

    logic [1:0]     state;
    logic [CW-1:0]  count;
    logic [2:0]     op_q;
    logic           sign_a;
    logic           sign_b;
    logic           b_zero;
    logic [N:0]     mag_b;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_step;
    logic           done_q;
    logic [N-1:0]   result_q;
    logic           zeroflag_q;

    logic           in_sa;
    logic           in_sb;
    logic [N-1:0]   in_mag_a;
    logic [N:0]     in_mag_b;

    logic [2*N-1:0] prod;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;
    logic [N-1:0]   fix_result;

    // Magnitudes are formed at N+1 bits so -2^(N-1) negates without wrapping.
    always_comb begin
        in_sa    = signed_a(bus.op_i) & bus.a_i[N-1];
        in_sb    = signed_b(bus.op_i) & bus.b_i[N-1];
        in_mag_a = in_sa ? N'((N+1)'(0) - {1'b1, bus.a_i}) : bus.a_i;
        in_mag_b = in_sb ? ((N+1)'(0) - {1'b1, bus.b_i}) : {1'b0, bus.b_i};
    end

    muldiv_step #(.N(N)) u_step (
        .is_div (is_div(op_q)),
        .acc_i  (acc),
        .b_i    (mag_b),
        .acc_o  (acc_step)
    );

    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc : acc;
        // Division by zero overrides the quotient; the remainder path already yields a.
        quo  = b_zero ? {N{1'b1}} : ((sign_a ^ sign_b) ? -acc[N-1:0] : acc[N-1:0]);
        rem  = sign_a ? -acc[2*N-1:N] : acc[2*N-1:N];
        case (op_q)
            MD_MUL:                       fix_result = prod[N-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod[2*N-1:N];
            default:                      fix_result = is_rem(op_q) ? rem : quo;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            count      <= '0;
            op_q       <= MD_MUL;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            b_zero     <= 1'b0;
            mag_b      <= '0;
            acc        <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zeroflag_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        op_q   <= bus.op_i;
                        sign_a <= in_sa;
                        sign_b <= in_sb;
                        mag_b  <= in_mag_b;
                        b_zero <= (bus.b_i == '0);
                        acc    <= {{N{1'b0}}, in_mag_a};
                        count  <= '0;
                        state  <= S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                        // Preload the accumulator with what CALC would have produced.
                        if (bus.a_i == '0 || bus.b_i == '0) begin
                            state <= S_FIX;
                            acc   <= (is_div(bus.op_i) && bus.b_i == '0) ?
                                     {in_mag_a, {N{1'b1}}} : '0;
                        end
`endif
                    end
                end
                S_CALC: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                    if (count == CW'(N-1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q   <= fix_result;
                    zeroflag_q <= (fix_result == '0);
                    done_q     <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o     = (state != S_IDLE);
    assign bus.done_o     = done_q;
    assign bus.result_o   = result_q;
    assign bus.zeroflag_o = zeroflag_q;

endmodule
